// File: rtl/keypad_scanner.sv
// keypad_scanner: column-walking 4x4 active-low keypad scanner with a
// full-map debouncer. Produces registered key levels, a key code, and a
// one-cycle press pulse. Every output changes only on the cycle after a commit.
module keypad_scanner #(
    parameter logic [15:0] SCAN_DIV       = 16'd5000,
    parameter logic [3:0]  DEBOUNCE_SCANS = 4'd4,
    parameter logic [3:0]  PLUS_CODE      = 4'd1,
    parameter logic [3:0]  MINUS_CODE     = 4'd9
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       plusIsPressed,
    output logic       minusIsPressed,
    output logic [3:0] keyCode,
    output logic       keyValid,
    output logic       keyPressPulse,
    output logic       multiKey
);

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} col_state_t;

    typedef struct packed {
        logic       plus;
        logic       minus;
        logic [3:0] code;
        logic       valid;
        logic       multi;
        logic       pulse;
    } key_out_t;

    col_state_t state, state_nx;
    logic [15:0] div;
    logic        div_last;
    logic [3:0]  row_s1, row_s2;
    logic [15:0] snap, prev_snap, stable;
    logic [3:0]  cnt, cnt_nx;
    logic        eval;
    logic        commit;
    logic [3:0]  code_nx;
    logic        multi_nx;
    key_out_t    kout;

    assign div_last = (div == SCAN_DIV - 16'd1);

    // Two-flop synchronizer; idle level is all rows high (no key).
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            row_s1 <= 4'hF;
            row_s2 <= 4'hF;
        end else begin
            row_s1 <= row_n;
            row_s2 <= row_s1;
        end
    end

    // Per-column dwell divider; wraps on the cycle the column advances.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)       div <= '0;
        else if (div_last) div <= '0;
        else               div <= div + 16'd1;
    end

    // Column FSM state register.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= COL0;
        else         state <= state_nx;
    end

    // Column FSM next state: step to the next column at the end of the dwell.
    always_comb begin
        state_nx = state;
        if (div_last) begin
            case (state)
                COL0: state_nx = COL1;
                COL1: state_nx = COL2;
                COL2: state_nx = COL3;
                COL3: state_nx = COL0;
            endcase
        end
    end

    // Column FSM output: drive exactly one column low.
    always_comb begin
        col_n = 4'b1110;
        case (state)
            COL0: col_n = 4'b1110;
            COL1: col_n = 4'b1101;
            COL2: col_n = 4'b1011;
            COL3: col_n = 4'b0111;
        endcase
    end

    // Capture the settled rows of the current column on its last cycle;
    // eval marks the cycle after the last column of a scan.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            snap <= '0;
            eval <= 1'b0;
        end else begin
            if (div_last) begin
                for (int r = 0; r < 4; r++)
                    snap[{r[1:0], state}] <= ~row_s2[r];
            end
            eval <= div_last && (state == COL3);
        end
    end

    // Debounce count update and commit decision for the whole map.
    always_comb begin
        cnt_nx = cnt;
        if (snap != prev_snap)          cnt_nx = 4'd1;
        else if (cnt >= DEBOUNCE_SCANS) cnt_nx = DEBOUNCE_SCANS;
        else                            cnt_nx = cnt + 4'd1;
        commit = eval && (cnt_nx == DEBOUNCE_SCANS) && (snap != stable);
    end

    // Key code (lowest set index) and multi-key flag of the map being committed.
    always_comb begin
        code_nx = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (snap[i]) code_nx = 4'(i);
        multi_nx = |(snap & (snap - 16'd1));
    end

    // Debounce state: history, count and committed map.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            prev_snap <= '0;
            cnt       <= '0;
            stable    <= '0;
        end else begin
            if (eval) begin
                prev_snap <= snap;
                cnt       <= cnt_nx;
            end
            if (commit) stable <= snap;
        end
    end

    // Output register: loads with the committed map; pulse only on new presses.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            kout <= '0;
        end else begin
            kout.pulse <= commit && |(snap & ~stable);
            if (commit) begin
                kout.plus  <= snap[PLUS_CODE];
                kout.minus <= snap[MINUS_CODE];
                kout.code  <= code_nx;
                kout.valid <= |snap;
                kout.multi <= multi_nx;
            end
        end
    end

    assign plusIsPressed  = kout.plus;
    assign minusIsPressed = kout.minus;
    assign keyCode        = kout.code;
    assign keyValid       = kout.valid;
    assign keyPressPulse  = kout.pulse;
    assign multiKey       = kout.multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_SCANS=3 (32-cycle scan).
// A keypad model drives rows from col_n; expected output changes (with the
// cycle they must appear on) are queued by the stimulus and consumed by a
// monitor whenever the output vector changes.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic        plusIsPressed, minusIsPressed, keyValid, keyPressPulse, multiKey;
    logic [3:0]  keyCode;
    logic [15:0] pressed = 16'h0000;
    int          cyc;
    int          n_cmp = 0;
    int          n_bad = 0;

    typedef struct packed {
        logic [15:0] t;
        logic        plus;
        logic        minus;
        logic [3:0]  code;
        logic        valid;
        logic        multi;
        logic        pulse;
    } ev_t;

    ev_t        exp_q[$];
    logic [8:0] prev_o = 9'd0;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV(16'd8), .DEBOUNCE_SCANS(4'd3), .PLUS_CODE(4'd1), .MINUS_CODE(4'd9)
    ) dut (
        .clk(clk), .resetN(resetN), .row_n(row_n), .col_n(col_n),
        .plusIsPressed(plusIsPressed), .minusIsPressed(minusIsPressed),
        .keyCode(keyCode), .keyValid(keyValid), .keyPressPulse(keyPressPulse),
        .multiKey(multiKey)
    );

    // Keypad matrix: a pressed key shorts its row to the driven-low column.
    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            row_n[r] = ~|(pressed[r*4 +: 4] & ~col_n);
    end

    // Cycle index since the last reset release.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic push_ev(input int t, input logic p, input logic m, input logic [3:0] c,
                           input logic v, input logic mk, input logic pu);
        ev_t e;
        e.t = 16'(t); e.plus = p; e.minus = m; e.code = c;
        e.valid = v; e.multi = mk; e.pulse = pu;
        exp_q.push_back(e);
    endtask

    task automatic go(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: column walk every cycle, queued output events on every change.
    always @(negedge clk) begin
        logic [3:0] exp_col;
        logic [8:0] cur;
        logic [8:0] want;
        ev_t        e;
        exp_col = 4'b1111 ^ (4'b0001 << cyc[4:3]);
        n_cmp++;
        if (col_n !== exp_col) begin
            n_bad++;
            $display("FAIL col_walk cyc=%0d got %b want %b", cyc, col_n, exp_col);
        end
        cur = {plusIsPressed, minusIsPressed, keyCode, keyValid, multiKey, keyPressPulse};
        if (cur !== prev_o) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output cyc=%0d got p%b m%b code%0d v%b mk%b pu%b",
                         cyc, cur[8], cur[7], cur[6:3], cur[2], cur[1], cur[0]);
            end else begin
                e = exp_q.pop_front();
                want = {e.plus, e.minus, e.code, e.valid, e.multi, e.pulse};
                if (cur !== want || cyc != int'(e.t)) begin
                    n_bad++;
                    $display("FAIL out_event got cyc=%0d p%b m%b code%0d v%b mk%b pu%b want cyc=%0d p%b m%b code%0d v%b mk%b pu%b",
                             cyc, cur[8], cur[7], cur[6:3], cur[2], cur[1], cur[0],
                             e.t, want[8], want[7], want[6:3], want[2], want[1], want[0]);
                end
            end
            prev_o = cur;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;

        // Idle through 200+ cycles, then key 1 from the start of scan 7.
        go(224);
        pressed = 16'h0002;
        push_ev(321, 1, 0, 4'd1, 1, 0, 1);
        push_ev(322, 1, 0, 4'd1, 1, 0, 0);
        go(352);
        pressed = 16'h0000;
        push_ev(449, 0, 0, 4'd0, 0, 0, 0);

        // Key 9 bouncing every 20 cycles for 4 scans, then solid.
        go(480);
        for (int t = 480; t < 608; t++) begin
            go(t);
            pressed[9] = (((t - 480) / 20) % 2) == 0;
        end
        go(608);
        pressed[9] = 1'b1;
        push_ev(705, 0, 1, 4'd9, 1, 0, 1);
        push_ev(706, 0, 1, 4'd9, 1, 0, 0);

        // Keys 1 and 9 together, then key 5 added.
        go(736);
        pressed = 16'h0202;
        push_ev(833, 1, 1, 4'd1, 1, 1, 1);
        push_ev(834, 1, 1, 4'd1, 1, 1, 0);
        go(864);
        pressed = 16'h0222;
        push_ev(961, 1, 1, 4'd1, 1, 1, 1);
        push_ev(962, 1, 1, 4'd1, 1, 1, 0);

        // Drop to key 1 alone: release-only commit, no pulse.
        go(992);
        pressed = 16'h0002;
        push_ev(1089, 1, 0, 4'd1, 1, 0, 0);

        // Reset in the middle of COL2 with key 1 held.
        go(1140);
        push_ev(0, 0, 0, 4'd0, 0, 0, 0);
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        push_ev(97, 1, 0, 4'd1, 1, 0, 1);
        push_ev(98, 1, 0, 4'd1, 1, 0, 0);

        // Key 15 glitch for exactly one scan: no output change.
        go(128);
        pressed = 16'h8002;
        go(160);
        pressed = 16'h0002;
        go(320);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending_events got %0d left want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
